// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_sequencer_pkg;

   // Sequencer states; S_HALT and S_FAULT are terminal until reset
   typedef enum logic [2:0] {
      S_RESET,
      S_FETCH,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [1:0] FAULT_NONE    = 2'b00;
   localparam logic [1:0] FAULT_ALIGN   = 2'b01;
   localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

   // Fixed A64 instruction size
   localparam logic [63:0] PC_STEP = 64'd4;

   // Instruction addresses must be word aligned; only the low two bits matter
   function automatic logic is_aligned(input logic [1:0] lo);
      return (lo == 2'b00);
   endfunction

endpackage

// File: rtl/ack_watchdog.sv
// Counts consecutive fetch cycles without an acknowledge and flags expiry.
// Latency: expired is combinational in the cycle the limit is reached.
// Backpressure: none; clr restarts the count, en advances it.
module ack_watchdog #(
   parameter int ACK_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // Count only needs to span 0..ACK_TIMEOUT-1; the last waiting cycle fires expiry
   localparam int W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [W-1:0] LAST = W'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);

   logic [W-1:0] cnt;

   // A limit of 0 disables the watchdog entirely
   assign expired = (ACK_TIMEOUT != 0) && en && (cnt == LAST);

   // Wait-cycle counter; cleared whenever the owner is not waiting in fetch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch sequencer: drives ProgramCounter.dirin, runs the imem req/ack handshake, tracks halt/fault/retired.
// Latency: min 2 cycles per instruction (ack in n, execute in n+1, new PC requested in n+2).
// Backpressure: waits in fetch for imem_ack (bounded by the watchdog); stall freezes the execute cycle.
module pc_sequencer #(
   parameter logic [63:0] RESET_VECTOR = 64'h0,
   parameter int          ACK_TIMEOUT  = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] dirout,
   output logic [63:0] dirin,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   input  logic        stall,
   input  logic        halt,
   output logic        halted,
   output logic        fault,
   output logic [1:0]  fault_code,
   output logic [31:0] retired
);

   import pc_sequencer_pkg::*;

   state_t state;
   logic   wd_clr;
   logic   wd_en;
   logic   wd_expired;
   logic   target_ok;

   // The PC register itself lives outside; we only ever fetch what it currently holds
   assign imem_addr = dirout;
   assign target_ok = is_aligned(branch_target[1:0]);

   // Watchdog runs only while waiting in fetch, so it is zero on every entry to fetch
   assign wd_clr = (state != S_FETCH);
   assign wd_en  = (state == S_FETCH) && !imem_ack;

   ack_watchdog #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Next-PC mux and handshake outputs; ProgramCounter reloads every edge, so "hold" means feeding dirout back
   always_comb begin
      dirin       = dirout;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      case (state)
         S_RESET: dirin = RESET_VECTOR;
         S_FETCH: imem_req = 1'b1;
         S_EXEC: begin
            instr_valid = 1'b1;
            if (stall || halt) begin
               dirin = dirout;
            end else if (branch_taken && !target_ok) begin
               dirin = dirout;
            end else if (branch_taken) begin
               dirin = branch_target;
            end else begin
               dirin = dirout + PC_STEP;
            end
         end
         S_HALT, S_FAULT: dirin = dirout;
         default: dirin = dirout;
      endcase
   end

   // Sequencer FSM with its registered outputs: instruction latch, retire count and sticky flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_RESET;
         instr      <= '0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         fault_code <= FAULT_NONE;
         retired    <= '0;
      end else begin
         case (state)
            S_RESET: state <= S_FETCH;
            S_FETCH: begin
               // stall has no effect here; only ack or the watchdog move us on
               if (imem_ack) begin
                  instr <= imem_data;
                  state <= S_EXEC;
               end else if (wd_expired) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= FAULT_TIMEOUT;
               end
            end
            S_EXEC: begin
               if (stall) begin
                  state <= S_EXEC;
               end else if (halt) begin
                  state   <= S_HALT;
                  halted  <= 1'b1;
                  retired <= retired + 32'd1;
               end else if (branch_taken && !target_ok) begin
                  // The faulting branch does not retire
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= FAULT_ALIGN;
               end else begin
                  state   <= S_FETCH;
                  retired <= retired + 32'd1;
               end
            end
            S_HALT, S_FAULT: state <= state;
            default: state <= S_RESET;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a behavioural ProgramCounter.
// Latency: n/a.
// Backpressure: bench acks fetches immediately or after a programmed delay.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] pc = 64'h0;
   logic [63:0] dirin;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = 64'h0;
   logic        stall = 1'b0;
   logic        halt = 1'b0;
   logic        halted;
   logic        fault;
   logic [1:0]  fault_code;
   logic [31:0] retired;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];
   logic [31:0] exp_retired = 32'h0;

   pc_sequencer #(
      .RESET_VECTOR (64'h100),
      .ACK_TIMEOUT  (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .dirout        (pc),
      .dirin         (dirin),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .stall         (stall),
      .halt          (halt),
      .halted        (halted),
      .fault         (fault),
      .fault_code    (fault_code),
      .retired       (retired)
   );

   initial forever #5 clk = ~clk;

   // Stand-in for ProgramCounter: no enable, reloads every rising edge
   always @(posedge clk) pc <= dirin;

   initial begin
      #200000;
      $display("FAIL global_timeout: run did not complete");
      $fatal(1, "bench time limit reached");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Hold reset for two cycles, check cleared state, release at a negedge
   task automatic apply_reset();
      reset = 1'b1;
      imem_ack = 1'b0;
      branch_taken = 1'b0;
      stall = 1'b0;
      halt = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_dirin", dirin, 64'h100);
      chk("rst_instr", instr, 32'h0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_fault", fault, 1'b0);
      chk("rst_code", fault_code, 2'b00);
      chk("rst_retired", retired, 32'h0);
      reset = 1'b0;
      exp_retired = 32'h0;
      exp_addr_q.delete();
      exp_instr_q.delete();
      exp_addr_q.push_back(64'h100);
   endtask

   // Wait for a request, check its address, ack after dly cycles, check the executing instruction
   task automatic fetch_one(input int dly, output logic [63:0] a);
      int          n;
      logic [31:0] d;
      logic [31:0] ei;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", imem_req, 1'b1);
      if (exp_addr_q.size() != 0) a = exp_addr_q.pop_front();
      else a = 64'hBAD0_BAD0_BAD0_BAD0;
      chk("imem_addr", imem_addr, a);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         chk("req_hold", imem_req, 1'b1);
      end
      d = a[31:0] ^ 32'hC0DE_0000;
      imem_ack = 1'b1;
      imem_data = d;
      exp_instr_q.push_back(d);
      @(negedge clk);
      imem_ack = 1'b0;
      chk("exec_valid", instr_valid, 1'b1);
      chk("exec_req", imem_req, 1'b0);
      if (exp_instr_q.size() != 0) ei = exp_instr_q.pop_front();
      else ei = 32'hDEAD_BEEF;
      chk("instr", instr, ei);
   endtask

   // Retire the executing instruction, sequentially or via an aligned branch
   task automatic exec_normal(input logic br, input logic [63:0] tgt, input logic [63:0] a);
      logic [63:0] nxt;
      nxt = br ? tgt : a + 64'd4;
      branch_taken = br;
      branch_target = tgt;
      #1;
      chk("dirin", dirin, nxt);
      exp_addr_q.push_back(nxt);
      exp_retired = exp_retired + 32'd1;
      @(negedge clk);
      branch_taken = 1'b0;
      chk("retired", retired, exp_retired);
      chk("post_valid", instr_valid, 1'b0);
   endtask

   logic [63:0] a;
   int          nreq;

   initial begin
      // Straight-line fetch, branches, wrap and misaligned fault
      apply_reset();
      fetch_one(0, a); exec_normal(1'b0, 64'h0, a);
      fetch_one(0, a); exec_normal(1'b0, 64'h0, a);
      fetch_one(0, a); exec_normal(1'b0, 64'h0, a);
      chk("retired_three", retired, 32'd3);
      fetch_one(3, a); exec_normal(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, a);
      chk("no_timeout_at_3", fault, 1'b0);
      fetch_one(0, a); exec_normal(1'b0, 64'h0, a);
      fetch_one(0, a); exec_normal(1'b1, 64'h104, a);
      fetch_one(0, a); exec_normal(1'b1, 64'h40, a);
      fetch_one(0, a); exec_normal(1'b1, 64'h104, a);
      fetch_one(0, a);
      branch_taken = 1'b1;
      branch_target = 64'h42;
      #1;
      chk("misalign_dirin", dirin, 64'h104);
      @(negedge clk);
      branch_taken = 1'b0;
      chk("misalign_fault", fault, 1'b1);
      chk("misalign_code", fault_code, 2'b01);
      chk("misalign_retired", retired, exp_retired);
      chk("misalign_halted", halted, 1'b0);
      imem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fault_pc", imem_addr, 64'h104);
         chk("fault_req", imem_req, 1'b0);
         chk("fault_valid", instr_valid, 1'b0);
      end
      imem_ack = 1'b0;

      // Stall with halt pending, then halt
      apply_reset();
      fetch_one(0, a); exec_normal(1'b0, 64'h0, a);
      fetch_one(0, a);
      stall = 1'b1;
      halt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_valid", instr_valid, 1'b1);
         chk("stall_dirin", dirin, a);
         chk("stall_retired", retired, exp_retired);
         @(negedge clk);
      end
      stall = 1'b0;
      #1;
      chk("halt_valid", instr_valid, 1'b1);
      chk("halt_dirin", dirin, a);
      exp_retired = exp_retired + 32'd1;
      @(negedge clk);
      halt = 1'b0;
      chk("halted", halted, 1'b1);
      chk("halt_retired", retired, exp_retired);
      chk("halt_fault", fault, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halt_pc", imem_addr, a);
         chk("halt_req", imem_req, 1'b0);
      end

      // Ack never arrives: exactly four request cycles, then timeout fault
      apply_reset();
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (imem_req) nreq++;
      end
      chk("timeout_req_cycles", nreq, 4);
      chk("timeout_fault", fault, 1'b1);
      chk("timeout_code", fault_code, 2'b10);
      chk("timeout_req_low", imem_req, 1'b0);
      chk("timeout_pc", imem_addr, 64'h100);

      // Reset mid-fetch drops the request asynchronously; late ack ignored
      apply_reset();
      fetch_one(0, a); exec_normal(1'b1, 64'h200, a);
      chk("mid_req", imem_req, 1'b1);
      chk("mid_addr", imem_addr, 64'h200);
      #2;
      reset = 1'b1;
      #1;
      chk("async_req_drop", imem_req, 1'b0);
      imem_ack = 1'b1;
      imem_data = 32'hFFFF_0000;
      apply_reset();
      fetch_one(0, a);
      chk("restart_addr", a, 64'h100);
      exec_normal(1'b0, 64'h0, a);
      chk("restart_retired", retired, 32'd1);
      chk("restart_fault", fault, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
